// File: rtl/adc_c2h_packer.sv
// Packs enabled ADC samples, sign-extended to 32-bit lanes, into AXI-Stream beats for XDMA C2H; one channel per cycle.
// First beat appears about 1 + (index of the LANES-th enabled channel) cycles after frame_valid; a full FIFO stalls the walk and later frames are dropped.
module adc_c2h_packer #(
  parameter int ADC_CHANNELS   = 4,
  parameter int ADC_DATA_WIDTH = 18,
  parameter int C_DATA_WIDTH   = 128,
  parameter int PKT_BEATS      = 1024,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                                   axi_aclk,
  input  logic                                   rst,
  input  logic                                   acq_en,
  input  logic                                   frame_valid,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_a_data_arr,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_b_data_arr,
  input  logic [2*ADC_CHANNELS-1:0]              channel_mask,
  output logic [C_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]              m_axis_tkeep,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast,
  output logic                                   overflow,
  output logic [31:0]                            frame_count
);
  localparam int LANES = C_DATA_WIDTH / 32;
  localparam int NK    = 2 * ADC_CHANNELS;
  localparam int KW    = $clog2(NK);
  localparam int LW    = $clog2(LANES);
  localparam int BW    = $clog2(PKT_BEATS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int KB    = C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WALK, FLUSH} state_t;

  state_t                       state_q;
  logic [NK*ADC_DATA_WIDTH-1:0] frame_q;
  logic [NK-1:0]                mask_q;
  logic [KW-1:0]                k_q;
  logic [LW-1:0]                lane_q;
  logic [C_DATA_WIDTH-1:0]      beat_q;
  logic [BW-1:0]                beat_cnt_q;
  logic                         acq_q;
  logic                         flush_pend_q;
  logic                         overflow_q;
  logic [31:0]                  frame_cnt_q;
  logic [AW-1:0]                wr_ptr_q;
  logic [AW-1:0]                rd_ptr_q;
  logic [AW:0]                  count_q;

  logic [C_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [KB-1:0]           mem_keep [FIFO_DEPTH];
  logic                    mem_last [FIFO_DEPTH];

  logic [31:0] ext [NK];
  for (genvar i = 0; i < NK; i++) begin : g_ext
    assign ext[i] = {{(33-ADC_DATA_WIDTH){frame_q[i*ADC_DATA_WIDTH + ADC_DATA_WIDTH-1]}},
                     frame_q[i*ADC_DATA_WIDTH +: ADC_DATA_WIDTH-1]};
  end

  logic [31:0]             sample;
  logic                    en_k, last_k, lane_last, beat_last;
  logic                    pop, full, space, stall;
  logic                    walk_push, flush_push, push, force_last;
  logic                    rise, fall, accept, drop;
  logic [C_DATA_WIDTH-1:0] push_data;
  logic [KB-1:0]           push_keep;
  logic                    push_last;

  always_comb begin
    sample     = ext[k_q];
    en_k       = mask_q[k_q];
    last_k     = (k_q == KW'(NK-1));
    lane_last  = (lane_q == LW'(LANES-1));
    beat_last  = (beat_cnt_q == BW'(PKT_BEATS-1));
    pop        = m_axis_tvalid & m_axis_tready;
    full       = (count_q == (AW+1)'(FIFO_DEPTH));
    space      = ~full | pop;
    stall      = (state_q == WALK) & en_k & lane_last & ~space;
    walk_push  = (state_q == WALK) & en_k & lane_last & space;
    flush_push = (state_q == FLUSH) & (lane_q != '0) & space;
    push       = walk_push | flush_push;
    // Only a beat queued behind the visible head may have tlast retrofitted.
    force_last = (state_q == FLUSH) & (lane_q == '0) & (beat_cnt_q != '0) & (count_q >= (AW+1)'(2));
    rise       = acq_en & ~acq_q;
    fall       = ~acq_en & acq_q;
    accept     = frame_valid & acq_en & (state_q == IDLE);
    drop       = frame_valid & ((state_q != IDLE) | ~acq_en);
    push_data  = beat_q;
    push_keep  = '1;
    push_last  = 1'b1;
    if (state_q == WALK) begin
      push_data[C_DATA_WIDTH-32 +: 32] = sample;
      push_last = beat_last;
    end else begin
      push_keep = '0;
      for (int l = 0; l < LANES; l++) begin
        if (l < int'(lane_q)) push_keep[l*4 +: 4] = 4'hF;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      mask_q       <= '0;
      k_q          <= '0;
      lane_q       <= '0;
      beat_q       <= '0;
      beat_cnt_q   <= '0;
      acq_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      acq_q       <= acq_en;
      overflow_q  <= (overflow_q & ~rise) | drop;
      frame_cnt_q <= (rise ? 32'd0 : frame_cnt_q) + {31'd0, accept};
      if (fall) flush_pend_q <= 1'b1;
      else if (rise || state_q == FLUSH) flush_pend_q <= 1'b0;

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            frame_q <= {adc_b_data_arr, adc_a_data_arr};
            mask_q  <= channel_mask;
            k_q     <= '0;
            state_q <= WALK;
          end else if (flush_pend_q) begin
            state_q <= FLUSH;
          end
        end
        WALK: begin
          if (!stall) begin
            if (en_k) begin
              if (lane_last) begin
                beat_q     <= '0;
                lane_q     <= '0;
                beat_cnt_q <= beat_last ? '0 : beat_cnt_q + 1'b1;
              end else begin
                beat_q[lane_q*32 +: 32] <= sample;
                lane_q <= lane_q + 1'b1;
              end
            end
            k_q <= k_q + 1'b1;
            if (last_k) state_q <= acq_en ? IDLE : FLUSH;
          end
        end
        FLUSH: begin
          if (lane_q == '0 || space) begin
            beat_q     <= '0;
            lane_q     <= '0;
            beat_cnt_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (rise) beat_cnt_q <= '0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= push_data;
      mem_keep[wr_ptr_q] <= push_keep;
      mem_last[wr_ptr_q] <= push_last;
    end
    if (force_last) mem_last[wr_ptr_q - 1'b1] <= 1'b1;
  end

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr_q] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? mem_keep[rd_ptr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid & mem_last[rd_ptr_q];
  assign overflow      = overflow_q;
  assign frame_count   = frame_cnt_q;
endmodule

// File: tb/tb_adc_c2h_packer.sv
// Directed bench for adc_c2h_packer: 4 channels/bank, 18-bit samples, 128-bit stream, 4-beat packets, 4-deep FIFO.
module tb_adc_c2h_packer;
  localparam int N = 4, W = 18, CW = 128, PB = 4, FD = 4;

  logic            axi_aclk = 1'b0;
  logic            rst = 1'b1, acq_en = 1'b0, frame_valid = 1'b0, tready = 1'b1;
  logic [N*W-1:0]  adc_a = '0, adc_b = '0;
  logic [2*N-1:0]  mask = '0;
  logic [CW-1:0]   tdata;
  logic [CW/8-1:0] tkeep;
  logic            tvalid, tlast, overflow;
  logic [31:0]     frame_count;

  adc_c2h_packer #(.ADC_CHANNELS(N), .ADC_DATA_WIDTH(W), .C_DATA_WIDTH(CW),
                   .PKT_BEATS(PB), .FIFO_DEPTH(FD)) dut (
    .axi_aclk(axi_aclk), .rst(rst), .acq_en(acq_en), .frame_valid(frame_valid),
    .adc_a_data_arr(adc_a), .adc_b_data_arr(adc_b), .channel_mask(mask),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .overflow(overflow),
    .frame_count(frame_count));

  always #5 axi_aclk = ~axi_aclk;

  int n_cmp = 0, n_err = 0;
  logic [CW-1:0]   q_data [$];
  logic [CW/8-1:0] q_keep [$];
  logic            q_last [$];

  // Record each accepted beat just before the edge that pops it.
  always @(negedge axi_aclk) begin
    #4;
    if (tvalid && tready) begin
      q_data.push_back(tdata);
      q_keep.push_back(tkeep);
      q_last.push_back(tlast);
    end
  end

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] v0, v1, v2, v3);
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [CW-1:0] beat4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge axi_aclk);
  endtask

  task automatic clear_q();
    q_data.delete(); q_keep.delete(); q_last.delete();
  endtask

  task automatic send_frame(input logic [N*W-1:0] a, b, input logic [2*N-1:0] m);
    @(negedge axi_aclk);
    adc_a = a; adc_b = b; mask = m; frame_valid = 1'b1;
    @(negedge axi_aclk);
    frame_valid = 1'b0;
  endtask

  task automatic restart();
    @(negedge axi_aclk); acq_en = 1'b0;
    cycles(5);
    acq_en = 1'b1;
    cycles(3);
  endtask

  task automatic test_reset();
    cycles(3);
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    n_cmp++; if (tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", tlast); end
    n_cmp++; if (tkeep !== '0) begin n_err++; $display("FAIL reset_tkeep got %h want 0", tkeep); end
    n_cmp++; if (tdata !== '0) begin n_err++; $display("FAIL reset_tdata got %h want 0", tdata); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (frame_count !== 32'd0) begin n_err++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    rst = 1'b0; acq_en = 1'b1;
    cycles(3);
  endtask

  task automatic test_basic();
    logic [CW-1:0] exp_d [2];
    int lat;
    exp_d[0] = beat4(32'd1, 32'd2, 32'd3, 32'd4);
    exp_d[1] = {CW{1'b1}};
    clear_q();
    send_frame(pack4(18'd1, 18'd2, 18'd3, 18'd4), {4{18'h3FFFF}}, 8'hFF);
    lat = 1;
    while (!tvalid && lat < 20) begin @(negedge axi_aclk); lat++; end
    n_cmp++; if (lat > 5) begin n_err++; $display("FAIL basic_latency got %0d cycles want <=5", lat); end
    cycles(10);
    n_cmp++; if (q_data.size() != 2) begin n_err++; $display("FAIL basic_beats got %0d want 2", q_data.size()); end
    if (q_data.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (q_data[i] !== exp_d[i]) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", i, q_data[i], exp_d[i]); end
        n_cmp++; if (q_keep[i] !== 16'hFFFF) begin n_err++; $display("FAIL basic_keep[%0d] got %h want ffff", i, q_keep[i]); end
        n_cmp++; if (q_last[i] !== 1'b0) begin n_err++; $display("FAIL basic_last[%0d] got %b want 0", i, q_last[i]); end
      end
    end
    n_cmp++; if (frame_count !== 32'd1) begin n_err++; $display("FAIL basic_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_mask05();
    logic [CW-1:0] exp_d;
    exp_d = beat4(32'h0001FFFF, 32'hFFFE0000, 32'h0001FFFF, 32'hFFFE0000);
    clear_q();
    send_frame(pack4(18'h1FFFF, 18'd0, 18'h20000, 18'd0), '0, 8'h05);
    cycles(11);
    send_frame(pack4(18'h1FFFF, 18'd0, 18'h20000, 18'd0), '0, 8'h05);
    cycles(12);
    n_cmp++; if (q_data.size() != 1) begin n_err++; $display("FAIL mask05_beats got %0d want 1", q_data.size()); end
    if (q_data.size() == 1) begin
      n_cmp++; if (q_data[0] !== exp_d) begin n_err++; $display("FAIL mask05_data got %h want %h", q_data[0], exp_d); end
      n_cmp++; if (q_keep[0] !== 16'hFFFF) begin n_err++; $display("FAIL mask05_keep got %h want ffff", q_keep[0]); end
    end
    n_cmp++; if (frame_count !== 32'd2) begin n_err++; $display("FAIL mask05_frame_count got %0d want 2", frame_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mask05_overflow got %b want 0", overflow); end
  endtask

  task automatic test_zero_mask();
    clear_q();
    send_frame(pack4(18'd7, 18'd7, 18'd7, 18'd7), '0, 8'h00);
    cycles(12);
    n_cmp++; if (q_data.size() != 0) begin n_err++; $display("FAIL zero_mask_beats got %0d want 0", q_data.size()); end
    n_cmp++; if (frame_count !== 32'd3) begin n_err++; $display("FAIL zero_mask_frame_count got %0d want 3", frame_count); end
  endtask

  task automatic test_tlast();
    logic [7:0] lastv;
    clear_q();
    for (int f = 0; f < 4; f++) begin
      send_frame(pack4(18'd1, 18'd2, 18'd3, 18'd4), pack4(18'd5, 18'd6, 18'd7, 18'd8), 8'hFF);
      cycles(9);
    end
    cycles(5);
    n_cmp++; if (q_data.size() != 8) begin n_err++; $display("FAIL tlast_beats got %0d want 8", q_data.size()); end
    lastv = '0;
    for (int i = 0; i < 8 && i < q_last.size(); i++) lastv[i] = q_last[i];
    n_cmp++; if (lastv !== 8'h88) begin n_err++; $display("FAIL tlast_pattern got %b want 10001000", lastv); end
    if (q_data.size() == 8) begin
      n_cmp++; if (q_data[5] !== beat4(32'd5, 32'd6, 32'd7, 32'd8)) begin n_err++; $display("FAIL tlast_data5 got %h", q_data[5]); end
    end
    n_cmp++; if (frame_count !== 32'd4) begin n_err++; $display("FAIL tlast_frame_count got %0d want 4", frame_count); end
  endtask

  task automatic test_overflow();
    logic [CW-1:0] head;
    head = beat4(32'd16, 32'd17, 32'd18, 32'd19);
    clear_q();
    @(negedge axi_aclk); tready = 1'b0;
    for (int f = 1; f <= 4; f++) begin
      send_frame(pack4(18'(16*f), 18'(16*f+1), 18'(16*f+2), 18'(16*f+3)),
                 pack4(18'(16*f+4), 18'(16*f+5), 18'(16*f+6), 18'(16*f+7)), 8'hFF);
      cycles(9);
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (frame_count !== 32'd3) begin n_err++; $display("FAIL ovf_frame_count got %0d want 3", frame_count); end
    n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL ovf_tvalid got %b want 1", tvalid); end
    n_cmp++; if (tdata !== head) begin n_err++; $display("FAIL ovf_head got %h want %h", tdata, head); end
    cycles(3);
    n_cmp++; if (tdata !== head) begin n_err++; $display("FAIL ovf_head_stable got %h want %h", tdata, head); end
    n_cmp++; if (q_data.size() != 0) begin n_err++; $display("FAIL ovf_no_pop got %0d want 0", q_data.size()); end
    tready = 1'b1;
    cycles(20);
    n_cmp++; if (q_data.size() != 6) begin n_err++; $display("FAIL ovf_drain_beats got %0d want 6", q_data.size()); end
    if (q_data.size() == 6) begin
      for (int f = 1; f <= 3; f++) begin
        for (int j = 0; j < 2; j++) begin
          logic [CW-1:0] e;
          e = beat4(32'(16*f+4*j), 32'(16*f+4*j+1), 32'(16*f+4*j+2), 32'(16*f+4*j+3));
          n_cmp++; if (q_data[(f-1)*2+j] !== e) begin n_err++; $display("FAIL ovf_drain[%0d] got %h want %h", (f-1)*2+j, q_data[(f-1)*2+j], e); end
        end
      end
    end
    restart();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_cleared got %b want 0", overflow); end
    n_cmp++; if (frame_count !== 32'd0) begin n_err++; $display("FAIL ovf_count_cleared got %0d want 0", frame_count); end
  endtask

  task automatic test_flush();
    clear_q();
    send_frame(pack4(18'd1, 18'd2, 18'd3, 18'd4), '0, 8'h07);
    acq_en = 1'b0;
    cycles(12);
    send_frame(pack4(18'd9, 18'd9, 18'd9, 18'd9), '0, 8'hFF);
    cycles(2);
    n_cmp++; if (q_data.size() != 1) begin n_err++; $display("FAIL flush_beats got %0d want 1", q_data.size()); end
    if (q_data.size() == 1) begin
      n_cmp++; if (q_data[0] !== beat4(32'd1, 32'd2, 32'd3, 32'd0)) begin n_err++; $display("FAIL flush_data got %h", q_data[0]); end
      n_cmp++; if (q_keep[0] !== 16'h0FFF) begin n_err++; $display("FAIL flush_keep got %h want 0fff", q_keep[0]); end
      n_cmp++; if (q_last[0] !== 1'b1) begin n_err++; $display("FAIL flush_last got %b want 1", q_last[0]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL flush_overflow got %b want 1", overflow); end
    n_cmp++; if (frame_count !== 32'd1) begin n_err++; $display("FAIL flush_frame_count got %0d want 1", frame_count); end
    acq_en = 1'b1;
    cycles(2);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reenable_overflow got %b want 0", overflow); end
    n_cmp++; if (frame_count !== 32'd0) begin n_err++; $display("FAIL reenable_frame_count got %0d want 0", frame_count); end
  endtask

  task automatic test_reset_midwalk();
    clear_q();
    @(negedge axi_aclk); tready = 1'b0;
    send_frame(pack4(18'd1, 18'd2, 18'd3, 18'd4), pack4(18'd5, 18'd6, 18'd7, 18'd8), 8'hFF);
    cycles(9);
    send_frame(pack4(18'd1, 18'd2, 18'd3, 18'd4), pack4(18'd5, 18'd6, 18'd7, 18'd8), 8'hFF);
    send_frame(pack4(18'd1, 18'd2, 18'd3, 18'd4), pack4(18'd5, 18'd6, 18'd7, 18'd8), 8'hFF);
    n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL pre_rst_tvalid got %b want 1", tvalid); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL pre_rst_overflow got %b want 1", overflow); end
    n_cmp++; if (frame_count !== 32'd2) begin n_err++; $display("FAIL pre_rst_frame_count got %0d want 2", frame_count); end
    rst = 1'b1;
    @(negedge axi_aclk); rst = 1'b0;
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_tvalid got %b want 0", tvalid); end
    n_cmp++; if (tdata !== '0) begin n_err++; $display("FAIL rst_mid_tdata got %h want 0", tdata); end
    n_cmp++; if (tkeep !== '0) begin n_err++; $display("FAIL rst_mid_tkeep got %h want 0", tkeep); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_mid_overflow got %b want 0", overflow); end
    n_cmp++; if (frame_count !== 32'd0) begin n_err++; $display("FAIL rst_mid_frame_count got %0d want 0", frame_count); end
    tready = 1'b1;
    cycles(2);
    clear_q();
    send_frame(pack4(18'd9, 18'd10, 18'd11, 18'd12), '0, 8'h0F);
    cycles(12);
    n_cmp++; if (q_data.size() != 1) begin n_err++; $display("FAIL post_rst_beats got %0d want 1", q_data.size()); end
    if (q_data.size() == 1) begin
      n_cmp++; if (q_data[0] !== beat4(32'd9, 32'd10, 32'd11, 32'd12)) begin n_err++; $display("FAIL post_rst_data got %h", q_data[0]); end
      n_cmp++; if (q_last[0] !== 1'b0) begin n_err++; $display("FAIL post_rst_last got %b want 0", q_last[0]); end
    end
    n_cmp++; if (frame_count !== 32'd1) begin n_err++; $display("FAIL post_rst_frame_count got %0d want 1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    restart();
    test_mask05();
    test_zero_mask();
    restart();
    test_tlast();
    restart();
    test_overflow();
    test_flush();
    test_reset_midwalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
